// File: rtl/alu_arbiter_if.sv
// Bundle for the ALU arbiter: two request channels, one response channel and
// the shared-ALU operand/result lines.
// slave  : the arbiter side (takes requests, drives the ALU and the response).
// master : the client/ALU side (issues requests, consumes responses, returns ALU results).
interface alu_arbiter_if #(
    parameter int unsigned DATA_W = 16
);
    // Requester 0
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [3:0]        req0_opcode;
    logic [3:0]        req0_opext;

    // Requester 1
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [3:0]        req1_opcode;
    logic [3:0]        req1_opext;

    // Response
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_id;
    logic [DATA_W-1:0] resp_data;
    logic [4:0]        resp_flags;

    // Shared ALU
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_opcode;
    logic [3:0]        alu_opext;
    logic [DATA_W-1:0] alu_s;
    logic [4:0]        alu_clfzn;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_opcode, req0_opext,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_opcode, req1_opext,
        output req1_ready,
        output resp_valid, resp_id, resp_data, resp_flags,
        input  resp_ready,
        output alu_a, alu_b, alu_opcode, alu_opext,
        input  alu_s, alu_clfzn
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_opcode, req0_opext,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_opcode, req1_opext,
        input  req1_ready,
        input  resp_valid, resp_id, resp_data, resp_flags,
        output resp_ready,
        input  alu_a, alu_b, alu_opcode, alu_opext,
        output alu_s, alu_clfzn
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single combinational ALU.
// One op at a time: latch operands, hold them on the ALU for ALU_WAIT cycles,
// capture S/CLFZN and return them tagged with the requester id.
// Optional feature: define ALU_ARB_RR_EN for round-robin arbitration; otherwise
// requester 0 has fixed priority.
// ALU_WAIT must be in 1..15 (the settle counter is 4 bits wide).
module alu_arbiter #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ALU_WAIT = 1
) (
    input logic         clk,
    input logic         rst_n,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    localparam logic [3:0] WaitInit = 4'(ALU_WAIT - 1);

    state_e            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;

    logic [DATA_W-1:0] alu_a_q, alu_b_q;
    logic [3:0]        alu_opcode_q, alu_opext_q;
    logic              resp_valid_q;
    logic              resp_id_q;
    logic [DATA_W-1:0] resp_data_q;
    logic [4:0]        resp_flags_q;

    logic              any_valid;
    logic              grant;        // 0 -> requester 0, 1 -> requester 1
    logic              accept;
    logic              capture;
    logic              retire;
    logic              ready0, ready1;

    logic [DATA_W-1:0] sel_a, sel_b;
    logic [3:0]        sel_opcode, sel_opext;

`ifdef ALU_ARB_RR_EN
    logic              last_grant_q;
`endif

    assign any_valid = bus.req0_valid | bus.req1_valid;

    // Arbitration: pick the winner purely from the current valids
    always_comb begin
`ifdef ALU_ARB_RR_EN
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = ~bus.req0_valid;
        end
`else
        grant = ~bus.req0_valid;
`endif
    end

    // Operand mux feeding the latch on accept
    always_comb begin
        sel_a      = grant ? bus.req1_a      : bus.req0_a;
        sel_b      = grant ? bus.req1_b      : bus.req0_b;
        sel_opcode = grant ? bus.req1_opcode : bus.req0_opcode;
        sel_opext  = grant ? bus.req1_opext  : bus.req0_opext;
    end

    // FSM next state, settle counter and handshake strobes
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        accept     = 1'b0;
        capture    = 1'b0;
        retire     = 1'b0;
        ready0     = 1'b0;
        ready1     = 1'b0;
        unique case (state_q)
            StIdle: begin
                // ready is only raised for a valid winner, so ready implies accept
                if (any_valid) begin
                    accept     = 1'b1;
                    ready0     = ~grant;
                    ready1     = grant;
                    wait_cnt_d = WaitInit;
                    state_d    = StExec;
                end
            end
            StExec: begin
                if (wait_cnt_q != 4'd0) begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end else begin
                    capture = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (bus.resp_ready) begin
                    retire  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and settle counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Operand latch: alu_* keep the last op after completion to avoid ALU toggling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= '0;
            alu_opext_q  <= '0;
            resp_id_q    <= 1'b0;
        end else if (accept) begin
            alu_a_q      <= sel_a;
            alu_b_q      <= sel_b;
            alu_opcode_q <= sel_opcode;
            alu_opext_q  <= sel_opext;
            resp_id_q    <= grant;
        end
    end

`ifdef ALU_ARB_RR_EN
    // Round-robin history; resets to 1 so the first contention favours requester 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else if (accept) begin
            last_grant_q <= grant;
        end
    end
`endif

    // Result capture and response valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_flags_q <= '0;
        end else if (capture) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= bus.alu_s;
            resp_flags_q <= bus.alu_clfzn;
        end else if (retire) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_flags = resp_flags_q;

    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_opcode = alu_opcode_q;
    assign bus.alu_opext  = alu_opext_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with ALU_WAIT=1 behind a small
// stub ALU, one with ALU_WAIT=4 whose ALU result is driven cycle by cycle.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_W(16)) bus ();
    alu_arbiter_if #(.DATA_W(16)) bus4 ();

    alu_arbiter #(.DATA_W(16), .ALU_WAIT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    alu_arbiter #(.DATA_W(16), .ALU_WAIT(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    // Stub ALU: opcode 0 adds, anything else XORs; flags {C, A<B, opext[0], Z, N}
    logic [16:0] stub_sum;
    logic [15:0] stub_s;
    logic        stub_c;
    always_comb begin
        stub_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        if (bus.alu_opcode == 4'h0) begin
            stub_s = stub_sum[15:0];
            stub_c = stub_sum[16];
        end else begin
            stub_s = bus.alu_a ^ bus.alu_b;
            stub_c = 1'b0;
        end
    end
    assign bus.alu_s     = stub_s;
    assign bus.alu_clfzn = {stub_c, (bus.alu_a < bus.alu_b), bus.alu_opext[0],
                            (stub_s == 16'h0), stub_s[15]};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_opcode = 0; bus.req0_opext = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_opcode = 0; bus.req1_opext = 0;
        bus.resp_ready = 0;
        bus4.req0_valid = 0; bus4.req0_a = 0; bus4.req0_b = 0; bus4.req0_opcode = 0;
        bus4.req0_opext = 0;
        bus4.req1_valid = 0; bus4.req1_a = 0; bus4.req1_b = 0; bus4.req1_opcode = 0;
        bus4.req1_opext = 0;
        bus4.resp_ready = 0; bus4.alu_s = 0; bus4.alu_clfzn = 0;
    endtask

    task automatic test_reset();
        int seen;
        rst_n = 0;
        step();
        checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
        checks++; if (bus.resp_data !== 16'h0) begin failures++; $display("FAIL rst_resp_data: got %h want 0000", bus.resp_data); end
        checks++; if (bus.resp_flags !== 5'h0) begin failures++; $display("FAIL rst_resp_flags: got %b want 00000", bus.resp_flags); end
        checks++; if (bus.alu_a !== 16'h0 || bus.alu_b !== 16'h0) begin failures++; $display("FAIL rst_alu_ab: got %h/%h want 0000/0000", bus.alu_a, bus.alu_b); end
        checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b%b want 00", bus.req0_ready, bus.req1_ready); end
        rst_n = 1;
        step();
        // Start an op on the long-wait instance and reset it mid-EXEC
        bus4.req0_valid = 1; bus4.req0_a = 16'hBEEF; bus4.req0_b = 16'h0001;
        step();
        bus4.req0_valid = 0;
        checks++; if (bus4.alu_a !== 16'hBEEF) begin failures++; $display("FAIL rst_pre_exec_alu_a: got %h want beef", bus4.alu_a); end
        step();
        rst_n = 0;
        #1;
        checks++; if (bus4.alu_a !== 16'h0) begin failures++; $display("FAIL rst_mid_alu_a: got %h want 0000", bus4.alu_a); end
        checks++; if (bus4.resp_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_resp_valid: got %b want 0", bus4.resp_valid); end
        step();
        rst_n = 1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus4.resp_valid || bus4.req0_ready || bus4.req1_ready) seen++;
            step();
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL rst_no_response: got %0d active cycles want 0", seen); end
        // IDLE after reset: a new valid is offered ready straight away
        bus4.req0_valid = 1;
        #1;
        checks++; if (bus4.req0_ready !== 1'b1) begin failures++; $display("FAIL rst_idle_ready: got %b want 1", bus4.req0_ready); end
        bus4.req0_valid = 0;
        step();
    endtask

    task automatic test_single_op();
        bus.resp_ready = 1;
        bus.req0_valid = 1; bus.req0_a = 16'h0003; bus.req0_b = 16'h0004;
        bus.req0_opcode = 4'h0; bus.req0_opext = 4'h0;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin failures++; $display("FAIL single_ready: got %b want 1", bus.req0_ready); end
        step();
        bus.req0_valid = 0;
        checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid: got %b want 0", bus.resp_valid); end
        checks++; if (bus.alu_a !== 16'h0003 || bus.alu_b !== 16'h0004) begin failures++; $display("FAIL single_alu_ab: got %h/%h want 0003/0004", bus.alu_a, bus.alu_b); end
        step();
        checks++; if (bus.resp_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b want 1", bus.resp_valid); end
        checks++; if (bus.resp_id !== 1'b0) begin failures++; $display("FAIL single_id: got %b want 0", bus.resp_id); end
        checks++; if (bus.resp_data !== 16'h0007) begin failures++; $display("FAIL single_data: got %h want 0007", bus.resp_data); end
        checks++; if (bus.resp_flags !== 5'b01000) begin failures++; $display("FAIL single_flags: got %b want 01000", bus.resp_flags); end
        step();
        checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL single_retire: got %b want 0", bus.resp_valid); end
    endtask

    task automatic test_contention();
        logic exp_id [4];
        logic got_id [4];
        logic [15:0] got_data [4];
        int n;
        int both_ready;
        int r1_ready;
`ifdef ALU_ARB_RR_EN
        exp_id[0] = 0; exp_id[1] = 1; exp_id[2] = 0; exp_id[3] = 1;
`else
        exp_id[0] = 0; exp_id[1] = 0; exp_id[2] = 0; exp_id[3] = 0;
`endif
        rst_n = 0;
        step();
        rst_n = 1;
        bus.resp_ready = 1;
        bus.req0_a = 16'h0001; bus.req0_b = 16'h0001; bus.req0_opcode = 4'h0;
        bus.req1_a = 16'h0002; bus.req1_b = 16'h0002; bus.req1_opcode = 4'h0;
        bus.req0_valid = 1; bus.req1_valid = 1;
        n = 0; both_ready = 0; r1_ready = 0;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            #1;
            if (bus.req0_ready && bus.req1_ready) both_ready++;
            if (bus.req1_ready) r1_ready++;
            if (bus.resp_valid && bus.resp_ready) begin
                got_id[n] = bus.resp_id;
                got_data[n] = bus.resp_data;
                n++;
                if (n == 4) begin
                    bus.req0_valid = 0; bus.req1_valid = 0;
                end
            end
            if (n < 4) step();
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        step();
        checks++; if (n !== 4) begin failures++; $display("FAIL cont_count: got %0d responses want 4", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (got_id[i] !== exp_id[i]) begin failures++; $display("FAIL cont_grant%0d: got %b want %b", i, got_id[i], exp_id[i]); end
            checks++; if (got_data[i] !== (exp_id[i] ? 16'h0004 : 16'h0002)) begin failures++; $display("FAIL cont_data%0d: got %h want %h", i, got_data[i], exp_id[i] ? 16'h0004 : 16'h0002); end
        end
        checks++; if (both_ready !== 0) begin failures++; $display("FAIL cont_one_ready: got %0d double-ready cycles want 0", both_ready); end
`ifndef ALU_ARB_RR_EN
        checks++; if (r1_ready !== 0) begin failures++; $display("FAIL cont_req1_starved: got %0d req1 ready cycles want 0", r1_ready); end
`endif
    endtask

    task automatic test_backpressure();
        bus.resp_ready = 0;
        bus.req1_valid = 1; bus.req1_a = 16'hFFFF; bus.req1_b = 16'h0002;
        bus.req1_opcode = 4'h0; bus.req1_opext = 4'h1;
        #1;
        checks++; if (bus.req1_ready !== 1'b1) begin failures++; $display("FAIL bp_accept: got %b want 1", bus.req1_ready); end
        step();
        bus.req1_valid = 0;
        bus.req0_valid = 1; bus.req0_a = 16'h0005; bus.req0_b = 16'h0006;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b1) begin failures++; $display("FAIL bp_hold_valid%0d: got v=%b id=%b want v=1 id=1", i, bus.resp_valid, bus.resp_id); end
            checks++; if (bus.resp_data !== 16'h0001 || bus.resp_flags !== 5'b10100) begin failures++; $display("FAIL bp_hold_data%0d: got %h/%b want 0001/10100", i, bus.resp_data, bus.resp_flags); end
            checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin failures++; $display("FAIL bp_ready%0d: got %b%b want 00", i, bus.req0_ready, bus.req1_ready); end
            step();
        end
        bus.resp_ready = 1;
        #1;
        checks++; if (bus.resp_valid !== 1'b1) begin failures++; $display("FAIL bp_release_valid: got %b want 1", bus.resp_valid); end
        step();
        checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL bp_done_valid: got %b want 0", bus.resp_valid); end
        checks++; if (bus.req0_ready !== 1'b1) begin failures++; $display("FAIL bp_idle_ready: got %b want 1", bus.req0_ready); end
        // Withdraw before the edge: nothing may be accepted
        bus.req0_valid = 0;
        step();
        step();
        checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL bp_withdraw: got %b want 0", bus.resp_valid); end
    endtask

    task automatic test_wait_window();
        bus4.resp_ready = 0;
        bus4.req0_valid = 1; bus4.req0_a = 16'h1234; bus4.req0_b = 16'h5678;
        bus4.req0_opcode = 4'h2; bus4.req0_opext = 4'h5;
        #1;
        checks++; if (bus4.req0_ready !== 1'b1) begin failures++; $display("FAIL win_accept: got %b want 1", bus4.req0_ready); end
        step();
        bus4.req0_valid = 0;
        for (int k = 0; k < 4; k++) begin
            bus4.alu_s = 16'hA000 + 16'(k);
            bus4.alu_clfzn = 5'(k + 1);
            checks++; if (bus4.alu_a !== 16'h1234 || bus4.alu_b !== 16'h5678 || bus4.alu_opext !== 4'h5) begin failures++; $display("FAIL win_stable%0d: got %h/%h/%h want 1234/5678/5", k, bus4.alu_a, bus4.alu_b, bus4.alu_opext); end
            checks++; if (bus4.resp_valid !== 1'b0) begin failures++; $display("FAIL win_early%0d: got %b want 0", k, bus4.resp_valid); end
            step();
        end
        bus4.alu_s = 16'hFFFF;
        bus4.alu_clfzn = 5'h1F;
        checks++; if (bus4.resp_valid !== 1'b1) begin failures++; $display("FAIL win_valid: got %b want 1", bus4.resp_valid); end
        checks++; if (bus4.resp_data !== 16'hA003 || bus4.resp_flags !== 5'd4) begin failures++; $display("FAIL win_capture: got %h/%b want a003/00100", bus4.resp_data, bus4.resp_flags); end
        step();
        checks++; if (bus4.resp_data !== 16'hA003) begin failures++; $display("FAIL win_hold: got %h want a003", bus4.resp_data); end
        bus4.resp_ready = 1;
        step();
        checks++; if (bus4.resp_valid !== 1'b0 || bus4.alu_a !== 16'h1234) begin failures++; $display("FAIL win_after: got v=%b a=%h want v=0 a=1234", bus4.resp_valid, bus4.alu_a); end
    endtask

    task automatic test_operand_change();
        bus.resp_ready = 1;
        bus.req0_valid = 1; bus.req0_a = 16'h0010; bus.req0_b = 16'h0020;
        bus.req0_opcode = 4'h0; bus.req0_opext = 4'h0;
        step();
        bus.req0_valid = 0; bus.req0_a = 16'hFFFF; bus.req0_b = 16'h0000;
        #1;
        checks++; if (bus.alu_a !== 16'h0010 || bus.alu_b !== 16'h0020) begin failures++; $display("FAIL opchg_latched: got %h/%h want 0010/0020", bus.alu_a, bus.alu_b); end
        step();
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 16'h0030) begin failures++; $display("FAIL opchg_result: got v=%b d=%h want v=1 d=0030", bus.resp_valid, bus.resp_data); end
        checks++; if (bus.resp_flags !== 5'b01000) begin failures++; $display("FAIL opchg_flags: got %b want 01000", bus.resp_flags); end
        step();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_wait_window();
        test_operand_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
